// File: rtl/multi_bank_reducer_if.sv
// Command/result channel plus the per-bank memory ports of the multi-bank reducer.
// master = reducer side, slave = channel FIFO and memory banks.
interface multi_bank_reducer_if #(
    parameter int unsigned W_A       = 10,
    parameter int unsigned W_D       = 32,
    parameter int unsigned NUM_BANKS = 4
) ();
    // First-word-fall-through command channel and result channel
    logic [W_D-1:0]       ch_q;
    logic                 ch_empty;
    logic                 ch_deq;
    logic [W_D-1:0]       ch_d;
    logic                 ch_full;
    logic                 ch_enq;

    // One single-port memory per bank; read data arrives one cycle after the address
    logic [W_A-1:0]       mem_addr [NUM_BANKS];
    logic [W_D-1:0]       mem_d    [NUM_BANKS];
    logic [NUM_BANKS-1:0] mem_we;
    logic [W_D-1:0]       mem_q    [NUM_BANKS];

    modport master (
        input  ch_q, ch_empty, ch_full, mem_q,
        output ch_deq, ch_d, ch_enq, mem_addr, mem_d, mem_we
    );

    modport slave (
        output ch_q, ch_empty, ch_full, mem_q,
        input  ch_deq, ch_d, ch_enq, mem_addr, mem_d, mem_we
    );
endinterface

// File: rtl/multi_bank_reducer.sv
// Reduces the first LEN words of every memory bank (SUM, MAX, XOR) or clears them,
// one command at a time, taking commands from and returning results to the channel.
module multi_bank_reducer #(
    parameter              THREAD_NAME = "ctrl_thread",
    parameter int unsigned W_A         = 10,
    parameter int unsigned W_COMM_A    = 4,
    parameter int unsigned W_D         = 32,
    parameter int unsigned NUM_BANKS   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    multi_bank_reducer_if.master bus,
    output logic                 busy,
    output logic [W_D-1:0]       result,
    output logic [15:0]          cmd_count
);
    localparam int unsigned W_B = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned W_L = W_A + 1;
    localparam logic [W_L-1:0] MAX_LEN = {1'b1, {W_A{1'b0}}};
    localparam logic [W_B-1:0] LAST_BANK = W_B'(NUM_BANKS - 1);

    if (W_D < 8 || NUM_BANKS < 1 || NUM_BANKS > 16 || W_COMM_A < 1 ||
        $bits(THREAD_NAME) < 8) begin : g_param_check
        $error("multi_bank_reducer: illegal parameterisation");
    end

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RUN, S_DRAIN, S_SEND} state_e;
    typedef enum logic [1:0] {OP_SUM, OP_MAX, OP_XOR, OP_CLEAR} op_e;

    state_e               state_q;
    op_e                  op_q;
    logic [W_L-1:0]       len_q;
    logic [W_B-1:0]       bank_q;
    logic [W_A-1:0]       addr_q;
    logic                 rd_valid_q;
    logic [W_B-1:0]       rd_bank_q;
    logic [W_D-1:0]       acc_q;
    logic                 deq_q;
    logic                 enq_q;
    logic [W_D-1:0]       ch_d_q;
    logic [W_A-1:0]       mem_addr_q [NUM_BANKS];
    logic [NUM_BANKS-1:0] we_q;

    logic [W_D-1:0]       acc_d;
    logic [W_D-1:0]       rd_data_c;
    logic [W_L-1:0]       cmd_len_c;
    logic                 last_addr_c;
    logic                 last_issue_c;
    logic [W_B-1:0]       next_bank_c;
    logic [W_A-1:0]       next_addr_c;
    logic                 send_now_c;
    logic [W_D-1:0]       send_val_c;
    logic                 unused_cmd_bits;

    assign unused_cmd_bits = ^bus.ch_q[W_D-3:W_A+1];

    // Clamp the requested length to the bank depth
    assign cmd_len_c = (bus.ch_q[W_A:0] > MAX_LEN) ? MAX_LEN : bus.ch_q[W_A:0];

    // Bank-major address walk; the bank steps on the same cycle the address wraps
    assign last_addr_c  = ({1'b0, addr_q} == (len_q - W_L'(1)));
    assign last_issue_c = last_addr_c && (bank_q == LAST_BANK);
    assign next_bank_c  = last_addr_c ? (bank_q + W_B'(1)) : bank_q;
    assign next_addr_c  = last_addr_c ? '0 : (addr_q + W_A'(1));

    // Fold the read returning this cycle into the accumulator; CLEAR counts words
    always_comb begin
        rd_data_c = bus.mem_q[rd_bank_q];
        acc_d     = acc_q;
        if (rd_valid_q) begin
            case (op_q)
                OP_SUM:  acc_d = acc_q + rd_data_c;
                OP_MAX:  acc_d = (rd_data_c > acc_q) ? rd_data_c : acc_q;
                OP_XOR:  acc_d = acc_q ^ rd_data_c;
                default: acc_d = acc_q + W_D'(1);
            endcase
        end
    end

    // The enqueue is registered, so it is decided on the edge that leaves DRAIN/DECODE
    assign send_now_c = !bus.ch_full &&
                        (((state_q == S_DECODE) && (len_q == '0)) ||
                         (state_q == S_DRAIN) || (state_q == S_SEND));
    assign send_val_c = (state_q == S_DECODE) ? '0 : acc_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            op_q       <= OP_SUM;
            len_q      <= '0;
            bank_q     <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            acc_q      <= '0;
            deq_q      <= 1'b0;
            enq_q      <= 1'b0;
            ch_d_q     <= '0;
            we_q       <= '0;
            busy       <= 1'b0;
            result     <= '0;
            cmd_count  <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                mem_addr_q[b] <= '0;
            end
        end else begin
            deq_q      <= 1'b0;
            enq_q      <= 1'b0;
            we_q       <= '0;
            rd_valid_q <= (state_q == S_RUN);
            rd_bank_q  <= bank_q;
            acc_q      <= acc_d;
            if (send_now_c) begin
                enq_q     <= 1'b1;
                ch_d_q    <= send_val_c;
                result    <= send_val_c;
                cmd_count <= cmd_count + 16'd1;
                busy      <= 1'b0;
                state_q   <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (deq_q) begin
                            state_q <= S_DECODE;
                        end else if (!bus.ch_empty) begin
                            deq_q <= 1'b1;
                            busy  <= 1'b1;
                            op_q  <= op_e'(bus.ch_q[W_D-1 -: 2]);
                            len_q <= cmd_len_c;
                        end
                    end
                    S_DECODE: begin
                        acc_q  <= '0;
                        bank_q <= '0;
                        addr_q <= '0;
                        if (len_q == '0) begin
                            state_q <= S_SEND;
                        end else begin
                            state_q       <= S_RUN;
                            mem_addr_q[0] <= '0;
                            we_q[0]       <= (op_q == OP_CLEAR);
                        end
                    end
                    S_RUN: begin
                        if (last_issue_c) begin
                            state_q <= S_DRAIN;
                        end else begin
                            bank_q                  <= next_bank_c;
                            addr_q                  <= next_addr_c;
                            mem_addr_q[next_bank_c] <= next_addr_c;
                            we_q[next_bank_c]       <= (op_q == OP_CLEAR);
                        end
                    end
                    S_DRAIN: state_q <= S_SEND;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign bus.ch_deq   = deq_q;
    assign bus.ch_enq   = enq_q;
    assign bus.ch_d     = ch_d_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = mem_addr_q;

    // Only CLEAR ever writes, and it always writes zero
    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_mem_d
        assign bus.mem_d[b] = '0;
    end
endmodule

// File: doc/multi_bank_reducer.md
# multi_bank_reducer

Parametrised successor to the single-bank summing user logic. It reduces the first LEN words of NUM_BANKS CoRAM memory banks into one result using the operation (SUM, MAX, XOR, CLEAR) named in a command word from the control thread. Commands arrive over one CoRAM channel, and each result is returned over the same channel. The block sits in the user-logic layer, between the CoRAM memory banks and the control thread named by THREAD_NAME.

## Interface
Parameters:
- THREAD_NAME, "ctrl_thread", CoRAM control thread bound to all memories and the channel
- W_A, 10, memory address width; bank depth 2^W_A
- W_COMM_A, 4, channel FIFO address width
- W_D, 32, memory, channel and accumulator data width (minimum 8)
- NUM_BANKS, 4, number of CoramMemory1P instances (1..16); bank b uses CORAM_ID 0, CORAM_SUB_ID b

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset, asynchronous assert, active-low; deassertion synchronous to CLK
- busy  out  1  high from command accept until result enqueue
- result  out  W_D  last result sent on the channel
- cmd_count  out  16  number of completed commands; wraps at 2^16

## Operation
- Command word on channel Q, bits [W_D-1:W_D-2] = opcode: 0 SUM, 1 MAX (unsigned), 2 XOR, 3 CLEAR.
- Command bits [W_A:0] = LEN, the words per bank. LEN values above 2^W_A are clamped to 2^W_A. All other bits are ignored.
- Channel is first-word-fall-through: Q is valid while EMPTY=0, and DEQ pops one word.
- States and transitions:
  - IDLE: when EMPTY=0, latch Q and pulse DEQ for one cycle, then go to DECODE.
  - DECODE: load the accumulator with 0 (the identity value for SUM, MAX and XOR). Reset bank and address counters to 0. If LEN=0, go to SEND; otherwise go to RUN.
  - RUN: issue one address per cycle, bank-major: bank 0 addresses 0..LEN-1, then bank 1, and so on. After the last address, go to DRAIN.
  - DRAIN: absorb the final read. Go to SEND.
  - SEND: when FULL=0, drive D=accumulator and pulse ENQ. In the same cycle, update result, increment cmd_count and go to IDLE. While FULL=1, hold.
- Read path:
  - Memory Q is valid one cycle after ADDR is presented.
  - A 1-bit valid flag plus a registered bank index tracks each read and selects the Q mux.
  - SUM: acc = acc + q, modulo 2^W_D, with no saturation.
  - MAX: acc = (q > acc) ? q : acc.
  - XOR: acc = acc ^ q.
- CLEAR:
  - In RUN, assert WE with D=0 for each address issued. Only the addressed bank receives WE.
  - The result is the number of words written, B×LEN, modulo 2^W_D.
- WE is never asserted outside a CLEAR RUN. Memory ADDR and D of idle banks hold their last values.
- Only one command is in flight at a time. No new DEQ is issued until SEND completes.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, result=0, cmd_count=0.
  - DEQ=0, ENQ=0, all WE=0.
  - Accumulator, addresses and channel D = 0.
- Cycle numbering: the DEQ-pulse cycle is cycle 0. DECODE is cycle 1, RUN occupies cycles 2..B×L+1, DRAIN is cycle B×L+2, and SEND is cycle B×L+3 at the earliest.
- ENQ rises at cycle B×L+3 when FULL=0. For LEN=0, ENQ is at cycle 2.
- busy rises on the edge that issues DEQ and falls on the edge that issues ENQ.
- ENQ and DEQ are single-cycle pulses, never asserted together.
- Minimum gap between commands: IDLE needs one cycle, so the next DEQ comes no earlier than one cycle after ENQ.
- Reset mid-operation:
  - All state returns to the reset values immediately, and any pending result is discarded.
  - A partially executed CLEAR leaves the banks partially cleared; this is acceptable.
  - Memory contents are otherwise untouched.
- Bank boundary: the address wraps from LEN-1 to 0 and the bank increments in the same cycle, with no bubble.

## Test plan
- SUM with NUM_BANKS=4: preload each bank with words 1..128 (addresses 0..127); send opcode 0, LEN=128 -> result 4×8256=33024, with ENQ exactly 515 cycles after DEQ.
- MAX and XOR: bank 2 addr 5 = 0xFFFF_FFF0, all other words 0x10; MAX with LEN=8 -> 0xFFFF_FFF0. Then bank 0 = {0xA5,0x5A}, other banks zero; XOR with LEN=2 -> 0xFF.
- CLEAR: send opcode 3, LEN=16 -> result 64. A following SUM with LEN=16 returns 0, and words at address 16 are unchanged.
- Edges:
  - LEN=0 SUM -> result 0, with ENQ at cycle 2.
  - LEN=2^W_A+5 -> treated as 1024 words.
  - SUM of 0xFFFF_FFFF twice -> 0xFFFF_FFFE (wrap).
- Back-pressure and reset: hold FULL=1 for 20 cycles in SEND -> ENQ is held off and busy stays 1; then release FULL -> exactly one ENQ. Assert RST mid-RUN -> busy=0, cmd_count=0, and no ENQ.
